// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: icache, dcache and main-memory signals of the shared block port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_done;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_done;
    logic              d_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_done, i_err, d_rdata, d_done, d_err, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_done, i_err, d_rdata, d_done, d_err, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory block port between icache and dcache,
// with registered outputs and a timeout abort for a memory that never answers.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(15);
    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d, d_done_q, d_done_d;
    logic              i_err_q, i_err_d, d_err_q, d_err_d;
    logic              any_req, pick_d, expired, grant, finish;
    // owner/last_grant encoding: 1 = dcache, 0 = icache
    assign any_req = bus.i_req | bus.d_req;
    assign pick_d  = bus.d_req & (~bus.i_req | ~last_q);
    assign expired = cnt_q == 16'(TIMEOUT - 1);
    assign grant   = state_q == IDLE && any_req;
    assign finish  = state_q == BUSY && (bus.mem_ready || expired);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_err_q     <= i_err_d;
            d_err_q     <= d_err_d;
        end
    end
    always_comb begin
        state_d = state_q == IDLE ? (any_req ? BUSY : IDLE)
                : state_q == BUSY ? (finish ? RELEASE : BUSY)
                : IDLE;
    end
    // mem_ready wins over a coinciding timeout, so err only flags a completion without ready
    always_comb begin
        owner_d     = grant ? pick_d : owner_q;
        last_d      = finish ? owner_q : last_q;
        cnt_d       = grant ? '0 : state_q == BUSY ? cnt_q + 16'd1 : cnt_q;
        mem_req_d   = grant ? 1'b1 : finish ? 1'b0 : mem_req_q;
        mem_we_d    = grant ? pick_d & bus.d_we : finish ? 1'b0 : mem_we_q;
        mem_addr_d  = grant ? (pick_d ? bus.d_addr : bus.i_addr) & ~LOW_MASK : mem_addr_q;
        mem_wdata_d = grant ? (pick_d && bus.d_we ? bus.d_wdata : '0) : mem_wdata_q;
        i_done_d    = finish & ~owner_q;
        d_done_d    = finish & owner_q;
        i_err_d     = i_done_d & ~bus.mem_ready;
        d_err_d     = d_done_d & ~bus.mem_ready;
        i_rdata_d   = finish && bus.mem_ready && !mem_we_q && !owner_q ? bus.mem_rdata : i_rdata_q;
        d_rdata_d   = finish && bus.mem_ready && !mem_we_q && owner_q ? bus.mem_rdata : d_rdata_q;
    end
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_err     = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven transfers plus contention, timeout and reset sequences,
// with expected completions queued at request time and checked at each done pulse.
module tb_mem_port_arbiter;
    localparam int TO = 4;
    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
        int          lat;
        logic [31:0] exp_addr;
        logic        exp_err;
    } vec_t;
    typedef struct {
        logic         is_d;
        logic         err;
        logic [127:0] rdata;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;
    logic [127:0] mi = '0;
    logic [127:0] md = '0;
    exp_t sb[$];
    vec_t tv[8];
    vec_t vi, vd, vw, v;
    mem_port_arbiter_if #(.ADDR_W(32), .LINE_W(128)) b();
    mem_port_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(TO)) dut (
        .clk(clk),
        .reset(reset),
        .bus(b)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    task automatic tick;
        @(negedge clk);
    endtask
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask
    function automatic vec_t mk(input logic is_d, input logic we, input logic [31:0] a,
                                input logic [127:0] wd, input logic [127:0] rd, input int lat,
                                input logic [31:0] ea, input logic ee);
        vec_t r;
        r.is_d = is_d; r.we = we; r.addr = a; r.wdata = wd; r.rdata = rd;
        r.lat = lat; r.exp_addr = ea; r.exp_err = ee;
        return r;
    endfunction
    task automatic present(input vec_t x);
        if (x.is_d) begin
            b.d_req = 1'b1; b.d_we = x.we; b.d_addr = x.addr; b.d_wdata = x.wdata;
        end else begin
            b.i_req = 1'b1; b.i_addr = x.addr;
        end
    endtask
    task automatic check_done;
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: actual i_done=%0b d_done=%0b required none", b.i_done, b.d_done);
        end else begin
            e = sb.pop_front();
            chk("i_done", 128'(b.i_done), 128'(!e.is_d));
            chk("d_done", 128'(b.d_done), 128'(e.is_d));
            chk("owner_err", 128'(e.is_d ? b.d_err : b.i_err), 128'(e.err));
            chk("other_err", 128'(e.is_d ? b.i_err : b.d_err), 128'(0));
            chk("i_rdata", b.i_rdata, mi);
            chk("d_rdata", b.d_rdata, md);
        end
    endtask
    // called at a negedge with the request already presented
    task automatic serve(input vec_t x, input logic drop);
        exp_t e;
        logic seen;
        e.is_d = x.is_d;
        e.err = x.exp_err;
        e.rdata = (x.we || x.exp_err) ? (x.is_d ? md : mi) : x.rdata;
        if (x.is_d) md = e.rdata; else mi = e.rdata;
        sb.push_back(e);
        tick();
        chk("mem_req", 128'(b.mem_req), 128'(1));
        chk("mem_we", 128'(b.mem_we), 128'(x.we));
        chk("mem_addr", 128'(b.mem_addr), 128'(x.exp_addr));
        chk("mem_wdata", b.mem_wdata, x.we ? x.wdata : 128'h0);
        seen = 1'b0;
        for (int n = 1; n <= 12 && !seen; n++) begin
            b.mem_ready = (n == x.lat);
            b.mem_rdata = (n == x.lat) ? x.rdata : {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            if (b.i_done || b.d_done) begin
                seen = 1'b1;
                check_done();
            end else begin
                chk("mem_hold", 128'({b.mem_req, b.mem_we, b.mem_addr}), 128'({1'b1, x.we, x.exp_addr}));
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL done_wait: actual no done in 12 cycles required done");
            sb = {};
        end
        b.mem_ready = 1'b0;
        if (drop) begin
            if (x.is_d) b.d_req = 1'b0; else b.i_req = 1'b0;
        end
        tick();
        chk("after_release", 128'({b.i_done, b.d_done, b.i_err, b.d_err, b.mem_req}), 128'(0));
    endtask
    initial begin
        b.i_req = 0; b.i_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0;
        b.mem_ready = 0; b.mem_rdata = 0;
        tv[0] = mk(0, 0, 32'h0000_0234, 128'h0, 128'h0123456789ABCDEF0123456789ABCDEF, 3, 32'h0000_0230, 0);
        tv[1] = mk(1, 1, 32'h0000_0108, {4{32'hAAAA_AAAA}}, 128'h0, 2, 32'h0000_0100, 0);
        tv[2] = mk(1, 0, 32'h0000_F00F, 128'h0, {4{32'h5555_5555}}, 1, 32'h0000_F000, 0);
        tv[3] = mk(1, 0, 32'h0000_0444, 128'h0, {4{32'h1111_2222}}, 0, 32'h0000_0440, 1);
        tv[4] = mk(0, 0, 32'h1234_5678, 128'h0, {4{32'hCAFE_F00D}}, 1, 32'h1234_5670, 0);
        tv[5] = mk(0, 0, 32'hFFFF_FFFF, 128'h0, {4{32'hDEAD_BEEF}}, TO, 32'hFFFF_FFF0, 0);
        tv[6] = mk(0, 0, 32'h0000_0010, 128'h0, {4{32'h7777_0000}}, 0, 32'h0000_0010, 1);
        tv[7] = mk(1, 1, 32'h8000_000C, {4{32'h3C3C_5A5A}}, 128'h0, 0, 32'h8000_0000, 1);
        vi = mk(0, 0, 32'h0000_1004, 128'h0, {4{32'h0BAD_CAFE}}, 2, 32'h0000_1000, 0);
        vd = mk(1, 0, 32'h0000_2008, 128'h0, {4{32'hFEED_FACE}}, 1, 32'h0000_2000, 0);
        vw = mk(1, 1, 32'h0000_0300, {4{32'hAAAA_AAAA}}, 128'h0, 1, 32'h0000_0300, 0);
        tick();
        tick();
        chk("rst_ctrl", 128'({b.mem_req, b.mem_we, b.i_done, b.d_done, b.i_err, b.d_err}), 128'(0));
        chk("rst_mem_addr", 128'(b.mem_addr), 128'(0));
        chk("rst_mem_wdata", b.mem_wdata, 128'h0);
        chk("rst_i_rdata", b.i_rdata, 128'h0);
        chk("rst_d_rdata", b.d_rdata, 128'h0);
        reset = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            present(tv[k]);
            serve(tv[k], 1'b1);
        end
        present(vi);
        present(vd);
        serve(vi, 1'b1);
        serve(vd, 1'b1);
        present(vi);
        present(vd);
        for (int k = 0; k < 4; k++) begin
            v = (k % 2 == 1) ? vd : vi;
            v.rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            serve(v, 1'b0);
        end
        b.i_req = 1'b0;
        b.d_req = 1'b0;
        tick();
        chk("contention_idle", 128'(b.mem_req), 128'(0));
        present(vi);
        serve(vi, 1'b1);
        present(vw);
        tick();
        chk("pre_reset_req", 128'(b.mem_req), 128'(1));
        tick();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_ctrl", 128'({b.mem_req, b.mem_we, b.i_done, b.d_done, b.i_err, b.d_err}), 128'(0));
        chk("async_rst_addr", 128'(b.mem_addr), 128'(0));
        chk("async_rst_wdata", b.mem_wdata, 128'h0);
        chk("async_rst_i_rdata", b.i_rdata, 128'h0);
        mi = '0;
        md = '0;
        b.d_req = 1'b0;
        b.d_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        present(vi);
        present(vd);
        serve(vi, 1'b1);
        serve(vd, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit main-memory block port between the instruction cache (read-only) and the data cache (read/write-through).
- Sits between both direct-mapped caches and main memory.
- Serialises cache miss and write-through transfers with round-robin fairness.
- Returns each transfer's line data and a one-cycle completion pulse; a timeout guards against a hung memory.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 128, cache line / memory block width in bits
TIMEOUT, 255, max cycles waiting for mem_ready before abort (1..65535)

Ports:
clk  in  1  system clock, rising edge active
reset  in  1  asynchronous, active-high reset
i_req  in  1  icache block-read request, level, held until i_done
i_addr  in  ADDR_W  icache byte address; bits [3:0] ignored
i_rdata  out  LINE_W  block returned to icache
i_done  out  1  one-cycle completion pulse to icache
i_err  out  1  one-cycle timeout flag, coincident with i_done
d_req  in  1  dcache request, level, held until d_done
d_we  in  1  1 = block write (write-through), 0 = block read
d_addr  in  ADDR_W  dcache byte address; bits [3:0] ignored
d_wdata  in  LINE_W  block to write when d_we=1
d_rdata  out  LINE_W  block returned to dcache
d_done  out  1  one-cycle completion pulse to dcache
d_err  out  1  one-cycle timeout flag, coincident with d_done
mem_req  out  1  memory transfer request, held until mem_ready or abort
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  block-aligned address, bits [3:0] = 0
mem_wdata  out  LINE_W  write block
mem_rdata  in  LINE_W  read block, valid when mem_ready=1
mem_ready  in  1  memory completion, sampled at rising clk

Behaviour:
- Reset, asynchronous on assertion, may occur mid-transfer:
  - state=IDLE; last_grant=D; timeout counter=0.
  - mem_req, mem_we, i_done, d_done, i_err, d_err = 0.
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0.
  - Any in-flight transfer is dropped with no done pulse; requesters re-request.
- All outputs are registered and change only on rising clk or on reset.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: grant the requester not equal to last_grant. After reset the icache wins the first tie.
  - On grant, latch into registers: owner, mem_addr = {addr[ADDR_W-1:4], 4'b0}, mem_we (0 for icache, d_we for dcache), mem_wdata (d_wdata for a dcache write, else 0).
  - Set mem_req=1, clear counter, go to BUSY. mem_req rises on the same edge that samples the request.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Requester inputs are ignored and not re-sampled.
- BUSY exit on mem_ready=1:
  - Drop mem_req and mem_we; set last_grant=owner; go to RELEASE.
  - For a read, copy mem_rdata into the owner's rdata register. The other requester's rdata is unchanged.
  - For a write, rdata is not updated.
  - Pulse owner_done=1 for exactly one cycle (the RELEASE cycle).
- BUSY, no mem_ready: counter increments each cycle.
- Timeout: when counter reaches TIMEOUT-1 with mem_ready still 0, abort.
  - Drop mem_req; go to RELEASE.
  - Pulse owner_done and owner_err together; rdata is unchanged; last_grant=owner.
  - mem_ready on the same edge as the timeout takes priority: normal completion, no err.
- RELEASE:
  - Lasts one cycle; done/err are high during it.
  - Requests are ignored; always go to IDLE.
  - The requester must drop req at the edge ending RELEASE. A req still high in IDLE is a new request.
- Minimum latency: req sampled at edge N, mem_ready high at edge N+1, done high during cycle N+1..N+2, IDLE again at N+2.
- Back-to-back arbitration:
  - A req already pending from the other requester is granted at the first IDLE edge, giving one idle mem_req cycle between transfers.
  - Under continuous contention, ownership strictly alternates.
- Only one done pulse is high at any time; i_done and d_done are never simultaneous.
- mem_rdata is ignored except at the completing edge of a read.

Test Plan:
- Reset, then i_req=1 with i_addr=0x0000_0234 → mem_req=1, mem_we=0, mem_addr=0x0000_0230 on the next cycle. mem_ready=1 after 3 cycles with mem_rdata=0x0123...CDEF → i_rdata=that value, i_done one cycle, d_done=0.
- d_req=1, d_we=1, d_addr=0x0000_0108, d_wdata=0xAA..AA → mem_we=1, mem_addr=0x0000_0100, mem_wdata=0xAA..AA held until mem_ready; d_done pulses; d_rdata unchanged.
- i_req and d_req both asserted on the same edge after reset → icache served first. The held d_req is granted at the next IDLE with one idle cycle between mem_req pulses. Repeat with continuous contention → grants alternate I,D,I,D.
- TIMEOUT=4, d_req read, mem_ready held 0 → mem_req drops after 4 BUSY cycles; d_done=d_err=1 for one cycle; d_rdata unchanged. A following i_req proceeds normally.
- Assert reset while BUSY with mem_req=1 → mem_req, done and err go 0 immediately, without waiting for a clock edge; the next grant after release behaves as after power-up (icache wins a tie).
- mem_ready=1 on the same edge the counter hits TIMEOUT-1 → normal completion, err=0, rdata updated.
